// File: rtl/iterative_barrel_shifter.sv
// Multi-cycle ARM data-processing shifter: normalises the shift specifier, then shifts
// BITS_PER_CYCLE bits per clock under a start/busy/done handshake.
module iterative_barrel_shifter #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        imm_mode,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  shift_amount,
  input  logic [31:0] value,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;
  typedef enum logic [2:0] {OpLsl, OpLsr, OpAsr, OpRor, OpRrx} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        imm_q, imm_d;
  logic [1:0]  type_q, type_d;
  logic [7:0]  amt_q, amt_d;
  logic [31:0] work_q, work_d;
  logic        cy_q, cy_d;
  logic [5:0]  rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;

  op_e         norm_op;
  logic [5:0]  norm_cnt;
  logic        norm_cy;
  logic [4:0]  amt5;

  logic [31:0] sh_work;
  logic        sh_cy;
  logic        sh_lsb;
  logic [5:0]  sh_step;
  logic [5:0]  sh_rem;

  // Turn the raw (imm_mode, type, amount) into an op and a single-bit step count.
  always_comb begin
    norm_op  = OpLsl;
    norm_cnt = '0;
    norm_cy  = cy_q;
    amt5     = amt_q[4:0];
    if (imm_q) begin
      case (type_q)
        2'b00: begin
          norm_op  = OpLsl;
          norm_cnt = {1'b0, amt5};
        end
        2'b01: begin
          norm_op  = OpLsr;
          norm_cnt = (amt5 == 5'd0) ? 6'd32 : {1'b0, amt5};
        end
        2'b10: begin
          norm_op  = OpAsr;
          norm_cnt = (amt5 == 5'd0) ? 6'd32 : {1'b0, amt5};
        end
        default: begin
          if (amt5 == 5'd0) begin
            norm_op  = OpRrx;
            norm_cnt = 6'd1;
          end else begin
            norm_op  = OpRor;
            norm_cnt = {1'b0, amt5};
          end
        end
      endcase
    end else if (amt_q != 8'd0) begin
      case (type_q)
        2'b00: begin
          norm_op  = OpLsl;
          norm_cnt = (amt_q > 8'd33) ? 6'd33 : amt_q[5:0];
        end
        2'b01: begin
          norm_op  = OpLsr;
          norm_cnt = (amt_q > 8'd33) ? 6'd33 : amt_q[5:0];
        end
        2'b10: begin
          norm_op  = OpAsr;
          norm_cnt = (amt_q > 8'd32) ? 6'd32 : amt_q[5:0];
        end
        default: begin
          norm_op = OpRor;
          if (amt5 == 5'd0) begin
            // Rotation by a multiple of 32 leaves the value intact but still sets carry.
            norm_cnt = '0;
            norm_cy  = work_q[31];
          end else begin
            norm_cnt = {1'b0, amt5};
          end
        end
      endcase
    end
  end

  // One SHIFT cycle: up to BITS_PER_CYCLE single-bit steps, stopping at the remaining count.
  always_comb begin
    sh_work = work_q;
    sh_cy   = cy_q;
    sh_lsb  = 1'b0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (i < int'(rem_q)) begin
        sh_lsb = sh_work[0];
        case (op_q)
          OpLsl: begin
            sh_cy   = sh_work[31];
            sh_work = {sh_work[30:0], 1'b0};
          end
          OpLsr:   sh_work = {1'b0, sh_work[31:1]};
          OpAsr:   sh_work = {sh_work[31], sh_work[31:1]};
          OpRor:   sh_work = {sh_lsb, sh_work[31:1]};
          default: sh_work = {sh_cy, sh_work[31:1]};
        endcase
        if (op_q != OpLsl) begin
          sh_cy = sh_lsb;
        end
      end
    end
    sh_step = (rem_q < 6'(BITS_PER_CYCLE)) ? rem_q : 6'(BITS_PER_CYCLE);
    sh_rem  = rem_q - sh_step;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    type_d   = type_q;
    amt_d    = amt_q;
    work_d   = work_q;
    cy_d     = cy_q;
    rem_d    = rem_q;
    result_d = result_q;
    carry_d  = carry_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StLoad;
          imm_d   = imm_mode;
          type_d  = shift_type;
          amt_d   = shift_amount;
          work_d  = value;
          cy_d    = carry_in;
        end
      end
      StLoad: begin
        op_d  = norm_op;
        rem_d = norm_cnt;
        cy_d  = norm_cy;
        if (norm_cnt == 6'd0) begin
          state_d  = StDone;
          result_d = work_q;
          carry_d  = norm_cy;
        end else begin
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = sh_work;
        cy_d   = sh_cy;
        rem_d  = sh_rem;
        if (sh_rem == 6'd0) begin
          state_d  = StDone;
          result_d = sh_work;
          carry_d  = sh_cy;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpLsl;
      imm_q    <= 1'b0;
      type_q   <= '0;
      amt_q    <= '0;
      work_q   <= '0;
      cy_q     <= 1'b0;
      rem_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      type_q   <= type_d;
      amt_q    <= amt_d;
      work_q   <= work_d;
      cy_q     <= cy_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign busy      = (state_q == StLoad) || (state_q == StShift);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_iterative_barrel_shifter.sv
// Directed bench for iterative_barrel_shifter at BITS_PER_CYCLE=1 and 4.
module tb_iterative_barrel_shifter;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start4;
  logic        imm_mode;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amount;
  logic [31:0] value;
  logic        carry_in;

  logic        busy1, done1, cy1;
  logic [31:0] res1;
  logic        busy4, done4, cy4;
  logic [31:0] res4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  iterative_barrel_shifter #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imm_mode     (imm_mode),
    .shift_type   (shift_type),
    .shift_amount (shift_amount),
    .value        (value),
    .carry_in     (carry_in),
    .busy         (busy1),
    .done         (done1),
    .result       (res1),
    .carry_out    (cy1)
  );

  iterative_barrel_shifter #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start4),
    .imm_mode     (imm_mode),
    .shift_type   (shift_type),
    .shift_amount (shift_amount),
    .value        (value),
    .carry_in     (carry_in),
    .busy         (busy4),
    .done         (done4),
    .result       (res4),
    .carry_out    (cy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic imm, input logic [1:0] typ, input logic [7:0] amt,
                       input logic [31:0] val, input logic cin, input bit wide);
    imm_mode     = imm;
    shift_type   = typ;
    shift_amount = amt;
    value        = val;
    carry_in     = cin;
    if (wide) start4 = 1'b1;
    else      start  = 1'b1;
  endtask

  // Latency counts clock edges from the accepting edge (1) until done is seen.
  task automatic wait_done(input bit wide, output int lat);
    @(posedge clk);
    #1;
    start  = 1'b0;
    start4 = 1'b0;
    lat    = 1;
    while (!(wide ? done4 : done1) && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic imm, input logic [1:0] typ,
                           input logic [7:0] amt, input logic [31:0] val, input logic cin,
                           input bit wide, input logic [31:0] exp_res, input logic exp_cy,
                           input int exp_lat);
    int lat;
    drive(imm, typ, amt, val, cin, wide);
    wait_done(wide, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, wide ? res4 : res1, exp_res);
    check({tag, " carry"}, {31'd0, wide ? cy4 : cy1}, {31'd0, exp_cy});
  endtask

  initial begin
    int          ndone;
    logic [31:0] got_res;
    got_res      = '0;
    reset        = 1'b1;
    start        = 1'b0;
    start4       = 1'b0;
    imm_mode     = 1'b0;
    shift_type   = LSL;
    shift_amount = '0;
    value        = '0;
    carry_in     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy1}, 32'd0);
    check("rst done", {31'd0, done1}, 32'd0);
    check("rst result", res1, 32'd0);
    check("rst carry", {31'd0, cy1}, 32'd0);
    check("rst result4", res4, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_check("reg lsl4", 0, LSL, 8'd4, 32'h8000_000F, 0, 0, 32'h0000_00F0, 0, 6);
    @(posedge clk);
    #1;
    check("done one cycle", {31'd0, done1}, 32'd0);

    run_check("imm lsr0", 1, LSR, 8'd0, 32'h8000_0001, 0, 0, 32'h0000_0000, 1, 34);
    run_check("imm asr0", 1, ASR, 8'd0, 32'h8000_0001, 0, 0, 32'hFFFF_FFFF, 1, 34);
    run_check("rrx", 1, ROR, 8'd0, 32'h0000_0003, 1, 0, 32'h8000_0001, 1, 3);
    run_check("reg lsl32", 0, LSL, 8'd32, 32'h8000_0001, 0, 0, 32'h0000_0000, 1, 34);
    run_check("reg lsl40", 0, LSL, 8'd40, 32'h8000_0001, 0, 0, 32'h0000_0000, 0, 35);
    run_check("reg ror32", 0, ROR, 8'd32, 32'h8000_0001, 0, 0, 32'h8000_0001, 1, 2);
    run_check("reg amt0", 0, ROR, 8'd0, 32'h8000_0001, 0, 0, 32'h8000_0001, 0, 2);

    run_check("b4 ror6", 0, ROR, 8'd6, 32'h0000_00FF, 0, 1, 32'hFC00_0003, 1, 4);
    run_check("b4 lsr33", 0, LSR, 8'd33, 32'h8000_0001, 1, 1, 32'h0000_0000, 0, 11);
    run_check("b4 asr0", 1, ASR, 8'd0, 32'h8000_0001, 0, 1, 32'hFFFF_FFFF, 1, 10);

    // start held (and inputs changed) while busy must not start or perturb anything.
    @(negedge clk);
    drive(0, LSL, 8'd4, 32'h8000_000F, 0, 0);
    @(posedge clk);
    #1;
    check("held busy", {31'd0, busy1}, 32'd1);
    value        = 32'h1234_5678;
    shift_amount = 8'd1;
    shift_type   = LSR;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    ndone = 0;
    repeat (12) begin
      if (done1) begin
        ndone++;
        got_res = res1;
      end
      @(posedge clk);
      #1;
    end
    check("held ndone", 32'(ndone), 32'd1);
    check("held result", got_res, 32'h0000_00F0);

    // Start in the DONE cycle: accepted, and the old result stays until the new done.
    run_check("b2b first", 0, LSL, 8'd4, 32'h8000_000F, 0, 0, 32'h0000_00F0, 0, 6);
    drive(0, ROR, 8'd1, 32'h0000_0001, 0, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy", {31'd0, busy1}, 32'd1);
    check("b2b hold1", res1, 32'h0000_00F0);
    @(posedge clk);
    #1;
    check("b2b hold2", res1, 32'h0000_00F0);
    check("b2b no done", {31'd0, done1}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b done", {31'd0, done1}, 32'd1);
    check("b2b result", res1, 32'h8000_0000);
    check("b2b carry", {31'd0, cy1}, 32'd1);

    // Reset mid-shift discards the op.
    @(negedge clk);
    drive(1, LSR, 8'd0, 32'h8000_0001, 0, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid busy", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid rst busy", {31'd0, busy1}, 32'd0);
    check("mid rst done", {31'd0, done1}, 32'd0);
    check("mid rst result", res1, 32'd0);
    check("mid rst carry", {31'd0, cy1}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done1) ndone++;
    end
    check("mid rst no done", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
